cache_miss_fsm: RTL and testbench
=================================

// Module: cache_miss_fsm
// PURPOSE
//  Per-cache miss/refill controller directly downstream of the replacement-policy block. Consumes its
//  one-hot victim way, latches it for the whole miss, writes back a dirty victim, fetches the new line
//  beat by beat, then commits it. Drives the policy's LRUWriteEn/SetValid strobes and stalls the pipeline.
// PARAMETERS
//  NUMWAYS    4   ways per set; one-hot victim width
//  BEATS      4   bus beats per cache line, power of two >= 2
// PORTS
//  clk             in   1        clock; all state updates on rising edge
//  reset_n         in   1        asynchronous, active-low reset
//  FlushStage      in   1        pipeline flush; suppresses starting a new request
//  CacheRW         in   2        2'b10 read, 2'b01 write, 2'b00 idle (2'b11 illegal)
//  Hit             in   1        tag match in current set
//  VictimWay       in   NUMWAYS  one-hot victim from replacement policy
//  VictimDirty     in   1        dirty bit of VictimWay in current set
//  BusReady        in   1        bus accepts/returns one beat this cycle
//  CacheStall      out  1        hold pipeline
//  LRUWriteEn      out  1        update replacement state
//  SetValid        out  1        set valid bit of LatchedWay
//  SetDirty        out  1        set dirty bit (hit write or committed write miss)
//  ClearDirty      out  1        clear dirty bit of LatchedWay after writeback
//  LatchedWay      out  NUMWAYS  way under refill; also the write-enable select for fill data
//  BusWriteReq     out  1        writeback request
//  BusFetchReq     out  1        line fetch request
//  FillBeatEn      out  1        write current fetched beat into LatchedWay
//  BeatIndex       out  log2(BEATS) beat number of current transfer
// BEHAVIOUR
//  Reset (async, reset_n=0): state READY, LatchedWay=0, BeatIndex=0, latched write flag=0; all strobes 0.
//  Req = (CacheRW!=0) & ~FlushStage.
//  READY: Req&Hit -> LRUWriteEn=1, SetDirty=CacheRW[0], CacheStall=0, stay.
//         Req&~Hit -> CacheStall=1 combinationally same cycle; capture VictimWay->LatchedWay, CacheRW[0]->
//         write flag; next state WRITEBACK if VictimDirty else FETCH. No strobes this cycle.
//         FlushStage=1 -> no strobes, no capture, stay READY.
//  WRITEBACK: BusWriteReq=1, CacheStall=1. Each BusReady cycle BeatIndex++. BusReady at BeatIndex==BEATS-1:
//         ClearDirty=1 that cycle, BeatIndex wraps to 0, -> FETCH.
//  FETCH: BusFetchReq=1, CacheStall=1, FillBeatEn=BusReady. Same counting; last beat -> COMMIT, index 0.
//  COMMIT (exactly 1 cycle): SetValid=1, LRUWriteEn=1, SetDirty=write flag, CacheStall=1 -> READY.
//         Request replays in READY next cycle and must then Hit.
//  Latency: clean miss = 1 + BEATS(BusReady-limited) + 1 cycles stall; dirty miss adds BEATS.
//  BusWriteReq and BusFetchReq never both 1; bus transaction never abandoned except by reset.
//  FlushStage, CacheRW, VictimWay, VictimDirty ignored outside READY (miss runs to completion).
//  BusReady=0 holds BeatIndex and state; no timeout.
//  LatchedWay stable from capture through COMMIT; holds last value in READY.
//  Reset mid-transfer: immediate return to READY values above; bus side tolerates abandoned burst.
//  CacheRW=2'b11 is a protocol violation: bench asserts it never occurs.
// STRUCTURE
//  cache_pkg: typedef enum {READY, WRITEBACK, FETCH, COMMIT} cache_miss_state_t; CacheRW encodings
//  (RW_IDLE, RW_READ, RW_WRITE).
//  Sub-module cache_beat_counter #(BEATS): clear/increment on BusReady, outputs BeatIndex and LastBeat.
//  FSM state and latched way/flag in flops with async active-low clear; outputs decoded from state.
// TESTING (NUMWAYS=4, BEATS=4)
//  Read hit: CacheRW=10,Hit=1 -> LRUWriteEn=1, SetDirty=0, CacheStall=0, state READY.
//  Clean read miss, VictimWay=0100, BusReady=1 every cycle -> FETCH 4 beats with FillBeatEn, BeatIndex 0..3,
//    COMMIT: SetValid=1,LRUWriteEn=1,LatchedWay=0100; CacheStall high exactly 6 cycles.
//  Dirty write miss, VictimWay=1000, BusReady toggling 1/0 -> 4 writeback beats, ClearDirty on beat 3,
//    4 fetch beats, COMMIT SetDirty=1; VictimWay changed to 0001 mid-miss leaves LatchedWay=1000.
//  FlushStage=1 with CacheRW=10,Hit=0 -> no capture, CacheStall=0, no bus request.
//  reset_n low during FETCH beat 2 -> same cycle all outputs 0, BeatIndex=0; next request starts clean.
//  Back-to-back: COMMIT then read hit on replayed request -> LRUWriteEn in consecutive cycles, no stall gap.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and encodings for the cache miss/refill controller.
//   cache_miss_state_t : FSM states of cache_miss_fsm
//   RW_IDLE/READ/WRITE : CacheRW request encodings (2'b11 is illegal)
package cache_pkg;

    typedef enum logic [1:0] {
        READY,
        WRITEBACK,
        FETCH,
        COMMIT
    } cache_miss_state_t;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b10;
    localparam logic [1:0] RW_WRITE = 2'b01;

endpackage

// File: rtl/cache_beat_counter.sv
// cache_beat_counter: counts bus beats of one line transfer, wrapping at BEATS.
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset, clears the count
//   inc        in   advance one beat
//   beat_index out  current beat number
//   last_beat  out  beat_index is the final beat of the line
module cache_beat_counter #(
    parameter int BEATS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     inc,
    output logic [$clog2(BEATS)-1:0] beat_index,
    output logic                     last_beat
);

    localparam int IW = $clog2(BEATS);

    // BEATS is a power of two, so the natural wrap returns to 0 after the last beat
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            beat_index <= '0;
        else if (inc)
            beat_index <= beat_index + 1'b1;

    assign last_beat = beat_index == IW'(BEATS - 1);

endmodule

// File: rtl/cache_miss_fsm.sv
// cache_miss_fsm: per-cache miss/refill controller (writeback, beat-wise fetch, commit).
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   FlushStage   in   suppresses starting a new request
//   CacheRW      in   2'b10 read, 2'b01 write, 2'b00 idle
//   Hit          in   tag match in current set
//   VictimWay    in   one-hot victim from replacement policy
//   VictimDirty  in   dirty bit of the victim
//   BusReady     in   bus moves one beat this cycle
//   CacheStall   out  hold pipeline
//   LRUWriteEn   out  update replacement state
//   SetValid     out  set valid bit of LatchedWay
//   SetDirty     out  set dirty bit
//   ClearDirty   out  clear dirty bit of LatchedWay after writeback
//   LatchedWay   out  way under refill / fill write-enable select
//   BusWriteReq  out  writeback request
//   BusFetchReq  out  line fetch request
//   FillBeatEn   out  write current fetched beat into LatchedWay
//   BeatIndex    out  beat number of current transfer
module cache_miss_fsm
    import cache_pkg::*;
#(
    parameter int NUMWAYS = 4,
    parameter int BEATS   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     FlushStage,
    input  logic [1:0]               CacheRW,
    input  logic                     Hit,
    input  logic [NUMWAYS-1:0]       VictimWay,
    input  logic                     VictimDirty,
    input  logic                     BusReady,
    output logic                     CacheStall,
    output logic                     LRUWriteEn,
    output logic                     SetValid,
    output logic                     SetDirty,
    output logic                     ClearDirty,
    output logic [NUMWAYS-1:0]       LatchedWay,
    output logic                     BusWriteReq,
    output logic                     BusFetchReq,
    output logic                     FillBeatEn,
    output logic [$clog2(BEATS)-1:0] BeatIndex
);

    cache_miss_state_t state, next_state;
    logic write_flag;
    logic capture;
    logic last_beat;
    logic req;

    assign req = (CacheRW != RW_IDLE) & ~FlushStage;

    // only bus-transfer states consume beats
    cache_beat_counter #(.BEATS(BEATS)) u_beat (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (BusReady & (state == WRITEBACK || state == FETCH)),
        .beat_index (BeatIndex),
        .last_beat  (last_beat)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= READY;
            LatchedWay <= '0;
            write_flag <= 1'b0;
        end else begin
            state <= next_state;
            if (capture) begin
                LatchedWay <= VictimWay;
                write_flag <= CacheRW == RW_WRITE;
            end
        end

    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        CacheStall  = 1'b0;
        LRUWriteEn  = 1'b0;
        SetValid    = 1'b0;
        SetDirty    = 1'b0;
        ClearDirty  = 1'b0;
        BusWriteReq = 1'b0;
        BusFetchReq = 1'b0;
        FillBeatEn  = 1'b0;
        case (state)
            READY:
                if (req && Hit) begin
                    LRUWriteEn = 1'b1;
                    SetDirty   = CacheRW == RW_WRITE;
                end else if (req) begin
                    // miss: stall immediately, victim and write intent frozen for the whole refill
                    CacheStall = 1'b1;
                    capture    = 1'b1;
                    next_state = VictimDirty ? WRITEBACK : FETCH;
                end
            WRITEBACK: begin
                CacheStall  = 1'b1;
                BusWriteReq = 1'b1;
                if (BusReady && last_beat) begin
                    ClearDirty = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                CacheStall  = 1'b1;
                BusFetchReq = 1'b1;
                FillBeatEn  = BusReady;
                if (BusReady && last_beat)
                    next_state = COMMIT;
            end
            default: begin
                // COMMIT: the request replays in READY next cycle and hits
                CacheStall = 1'b1;
                SetValid   = 1'b1;
                LRUWriteEn = 1'b1;
                SetDirty   = write_flag;
                next_state = READY;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_miss_fsm.sv
// tb_cache_miss_fsm: table-driven scoreboard bench for cache_miss_fsm (NUMWAYS=4, BEATS=4).
module tb_cache_miss_fsm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       FlushStage = 1'b0;
    logic [1:0] CacheRW = 2'b00;
    logic       Hit = 1'b0;
    logic [3:0] VictimWay = 4'b0000;
    logic       VictimDirty = 1'b0;
    logic       BusReady = 1'b0;
    logic       CacheStall, LRUWriteEn, SetValid, SetDirty, ClearDirty;
    logic       BusWriteReq, BusFetchReq, FillBeatEn;
    logic [3:0] LatchedWay;
    logic [1:0] BeatIndex;

    cache_miss_fsm #(.NUMWAYS(4), .BEATS(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .FlushStage  (FlushStage),
        .CacheRW     (CacheRW),
        .Hit         (Hit),
        .VictimWay   (VictimWay),
        .VictimDirty (VictimDirty),
        .BusReady    (BusReady),
        .CacheStall  (CacheStall),
        .LRUWriteEn  (LRUWriteEn),
        .SetValid    (SetValid),
        .SetDirty    (SetDirty),
        .ClearDirty  (ClearDirty),
        .LatchedWay  (LatchedWay),
        .BusWriteReq (BusWriteReq),
        .BusFetchReq (BusFetchReq),
        .FillBeatEn  (FillBeatEn),
        .BeatIndex   (BeatIndex)
    );

    always #5 clk = ~clk;

    // packed outputs: {stall, lru, setvalid, setdirty, cleardirty, buswr, busfetch, fill, way[3:0], beat[1:0]}
    typedef struct {
        string      name;
        logic       flush;
        logic [1:0] rw;
        logic       hit;
        logic [3:0] victim;
        logic       vdirty;
        logic       ready;
        logic [13:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [13:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [13:0] o(logic st, logic lru, logic sv, logic sd, logic cd,
                                      logic bw, logic bf, logic fl, logic [3:0] w, logic [1:0] b);
        return {st, lru, sv, sd, cd, bw, bf, fl, w, b};
    endfunction

    function automatic logic [13:0] outs();
        return {CacheStall, LRUWriteEn, SetValid, SetDirty, ClearDirty,
                BusWriteReq, BusFetchReq, FillBeatEn, LatchedWay, BeatIndex};
    endfunction

    task automatic add(string n, logic f, logic [1:0] rw, logic h, logic [3:0] v, logic d,
                       logic r, logic [13:0] e);
        vec_t x;
        x.name = n; x.flush = f; x.rw = rw; x.hit = h; x.victim = v; x.vdirty = d; x.ready = r; x.exp = e;
        vecs.push_back(x);
    endtask

    // drive one cycle's inputs just after the edge and queue the expected outputs for that cycle
    task automatic run_row(vec_t x);
        sb_t s;
        @(posedge clk);
        #1;
        FlushStage = x.flush; CacheRW = x.rw; Hit = x.hit;
        VictimWay = x.victim; VictimDirty = x.vdirty; BusReady = x.ready;
        s.name = x.name; s.exp = x.exp;
        sb.push_back(s);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t s;
            s = sb.pop_front();
            checks++;
            if (outs() !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.name, outs(), s.exp);
            end
        end
    end

    always @(negedge clk)
        if (reset_n)
            assert (CacheRW != 2'b11) else $error("illegal CacheRW=2'b11 driven");

    initial begin
        // reset and hits
        add("reset_idle",  0, 2'b00, 0, 4'b0000, 0, 0, o(0,0,0,0,0,0,0,0,4'b0000,2'd0));
        add("read_hit",    0, 2'b10, 1, 4'b0001, 0, 0, o(0,1,0,0,0,0,0,0,4'b0000,2'd0));
        add("write_hit",   0, 2'b01, 1, 4'b0001, 1, 0, o(0,1,0,1,0,0,0,0,4'b0000,2'd0));
        // clean read miss, bus always ready: 6 stall cycles
        add("cm_ready",    0, 2'b10, 0, 4'b0100, 0, 1, o(1,0,0,0,0,0,0,0,4'b0000,2'd0));
        add("cm_f0",       0, 2'b10, 0, 4'b0100, 0, 1, o(1,0,0,0,0,0,1,1,4'b0100,2'd0));
        add("cm_f1",       0, 2'b10, 0, 4'b0100, 0, 1, o(1,0,0,0,0,0,1,1,4'b0100,2'd1));
        add("cm_f2",       0, 2'b10, 0, 4'b0100, 0, 1, o(1,0,0,0,0,0,1,1,4'b0100,2'd2));
        add("cm_f3",       0, 2'b10, 0, 4'b0100, 0, 1, o(1,0,0,0,0,0,1,1,4'b0100,2'd3));
        add("cm_commit",   0, 2'b10, 0, 4'b0100, 0, 1, o(1,1,1,0,0,0,0,0,4'b0100,2'd0));
        add("cm_replay",   0, 2'b10, 1, 4'b0100, 0, 0, o(0,1,0,0,0,0,0,0,4'b0100,2'd0));
        // flushed miss neither captures nor stalls
        add("flush_miss",  1, 2'b10, 0, 4'b0001, 1, 1, o(0,0,0,0,0,0,0,0,4'b0100,2'd0));
        add("flush_after", 0, 2'b00, 0, 4'b0001, 1, 1, o(0,0,0,0,0,0,0,0,4'b0100,2'd0));
        // dirty write miss with BusReady toggling, victim changes mid-miss
        add("dm_ready",    0, 2'b01, 0, 4'b1000, 1, 0, o(1,0,0,0,0,0,0,0,4'b0100,2'd0));
        add("dm_w0",       0, 2'b01, 0, 4'b0001, 0, 1, o(1,0,0,0,0,1,0,0,4'b1000,2'd0));
        add("dm_w1_wait",  0, 2'b01, 0, 4'b0001, 0, 0, o(1,0,0,0,0,1,0,0,4'b1000,2'd1));
        add("dm_w1",       0, 2'b01, 0, 4'b0001, 0, 1, o(1,0,0,0,0,1,0,0,4'b1000,2'd1));
        add("dm_w2_wait",  0, 2'b01, 0, 4'b0001, 0, 0, o(1,0,0,0,0,1,0,0,4'b1000,2'd2));
        add("dm_w2",       1, 2'b01, 0, 4'b0001, 0, 1, o(1,0,0,0,0,1,0,0,4'b1000,2'd2));
        add("dm_w3_wait",  0, 2'b01, 0, 4'b0001, 0, 0, o(1,0,0,0,0,1,0,0,4'b1000,2'd3));
        add("dm_w3",       0, 2'b01, 0, 4'b0001, 0, 1, o(1,0,0,0,1,1,0,0,4'b1000,2'd3));
        add("dm_f0_wait",  0, 2'b01, 0, 4'b0001, 0, 0, o(1,0,0,0,0,0,1,0,4'b1000,2'd0));
        add("dm_f0",       0, 2'b01, 0, 4'b0001, 0, 1, o(1,0,0,0,0,0,1,1,4'b1000,2'd0));
        add("dm_f1_wait",  0, 2'b01, 0, 4'b0001, 0, 0, o(1,0,0,0,0,0,1,0,4'b1000,2'd1));
        add("dm_f1",       0, 2'b01, 0, 4'b0001, 0, 1, o(1,0,0,0,0,0,1,1,4'b1000,2'd1));
        add("dm_f2_wait",  0, 2'b01, 0, 4'b0001, 0, 0, o(1,0,0,0,0,0,1,0,4'b1000,2'd2));
        add("dm_f2",       0, 2'b01, 0, 4'b0001, 0, 1, o(1,0,0,0,0,0,1,1,4'b1000,2'd2));
        add("dm_f3_wait",  0, 2'b01, 0, 4'b0001, 0, 0, o(1,0,0,0,0,0,1,0,4'b1000,2'd3));
        add("dm_f3",       0, 2'b01, 0, 4'b0001, 0, 1, o(1,0,0,0,0,0,1,1,4'b1000,2'd3));
        add("dm_commit",   0, 2'b01, 0, 4'b0001, 0, 0, o(1,1,1,1,0,0,0,0,4'b1000,2'd0));
        add("dm_replay",   0, 2'b01, 1, 4'b0001, 0, 0, o(0,1,0,1,0,0,0,0,4'b1000,2'd0));
        add("idle_end",    0, 2'b00, 0, 4'b0000, 0, 0, o(0,0,0,0,0,0,0,0,4'b1000,2'd0));
        // clean miss to be cut by reset at fetch beat 2
        add("rs_ready",    0, 2'b10, 0, 4'b0010, 0, 1, o(1,0,0,0,0,0,0,0,4'b1000,2'd0));
        add("rs_f0",       0, 2'b10, 0, 4'b0010, 0, 1, o(1,0,0,0,0,0,1,1,4'b0010,2'd0));
        add("rs_f1",       0, 2'b10, 0, 4'b0010, 0, 1, o(1,0,0,0,0,0,1,1,4'b0010,2'd1));
        add("rs_f2",       0, 2'b10, 0, 4'b0010, 0, 1, o(1,0,0,0,0,0,1,1,4'b0010,2'd2));

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++)
            run_row(vecs[i]);

        // asynchronous reset mid-fetch: outputs clear without waiting for an edge
        @(negedge clk);
        #1;
        CacheRW = 2'b00; Hit = 1'b0; BusReady = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (outs() !== o(0,0,0,0,0,0,0,0,4'b0000,2'd0)) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", outs(), o(0,0,0,0,0,0,0,0,4'b0000,2'd0));
        end
        @(posedge clk);
        #2 reset_n = 1'b1;

        // fresh clean miss after reset starts at beat 0
        vecs.delete();
        add("pr_ready",    0, 2'b10, 0, 4'b0001, 0, 1, o(1,0,0,0,0,0,0,0,4'b0000,2'd0));
        add("pr_f0",       0, 2'b10, 0, 4'b0001, 0, 1, o(1,0,0,0,0,0,1,1,4'b0001,2'd0));
        add("pr_f1",       0, 2'b10, 0, 4'b0001, 0, 1, o(1,0,0,0,0,0,1,1,4'b0001,2'd1));
        add("pr_f2",       0, 2'b10, 0, 4'b0001, 0, 1, o(1,0,0,0,0,0,1,1,4'b0001,2'd2));
        add("pr_f3",       0, 2'b10, 0, 4'b0001, 0, 1, o(1,0,0,0,0,0,1,1,4'b0001,2'd3));
        add("pr_commit",   0, 2'b10, 0, 4'b0001, 0, 0, o(1,1,1,0,0,0,0,0,4'b0001,2'd0));
        add("pr_replay",   0, 2'b10, 1, 4'b0001, 0, 0, o(0,1,0,0,0,0,0,0,4'b0001,2'd0));
        add("pr_idle",     0, 2'b00, 0, 4'b0000, 0, 0, o(0,0,0,0,0,0,0,0,4'b0001,2'd0));
        for (int i = 0; i < vecs.size(); i++)
            run_row(vecs[i]);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
